// File: rtl/uart_byte_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_rx_if
// Purpose  : Byte handshake between uart_byte_rx and its consumer.
// Optional : UART_RX_PARITY_EN adds the rx_parity_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_byte_rx_if;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  modport master (
    input  rx_ready,
    output rx_data_out, rx_valid, rx_frame_err, rx_overrun
`ifdef UART_RX_PARITY_EN
    , output rx_parity_err
`endif
  );

  modport slave (
    output rx_ready,
    input  rx_data_out, rx_valid, rx_frame_err, rx_overrun
`ifdef UART_RX_PARITY_EN
    , input rx_parity_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_rx
// Purpose  : 8N1 UART receiver with a one-entry valid/ready holding register.
// Optional : UART_RX_PARITY_EN switches the frame to 8E1 with parity check.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic       rx_serial,
  input  wire logic       rx_enable,
  uart_byte_rx_if.master  rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_STOP   = 3'd3;
  localparam logic [2:0] c_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd5;
`endif

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic             r_sync1;
  logic             r_rxs;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_frame_err;
  logic             r_overrun;
  logic             w_mid;
  logic             w_half;
  logic             w_bit_sample;
  logic             w_stop_sample;
  logic             w_par_bad;
  logic             w_byte_done;
  logic             w_frame_bad;
`ifdef UART_RX_PARITY_EN
  logic             r_par_bit;
  logic             r_parity_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx_serial;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (!r_rxs && rx_enable) w_next_state = c_START;
      c_START: if (w_half) w_next_state = r_rxs ? c_IDLE : c_DATA;
`ifdef UART_RX_PARITY_EN
      c_DATA:   if (w_mid && r_bit_cnt == 3'd7) w_next_state = c_PARITY;
      c_PARITY: if (w_mid) w_next_state = c_STOP;
`else
      c_DATA:   if (w_mid && r_bit_cnt == 3'd7) w_next_state = c_STOP;
`endif
      c_STOP:  if (w_mid) w_next_state = r_rxs ? c_IDLE : c_BREAK;
      c_BREAK: if (r_rxs) w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_comb begin
    w_mid         = (r_cnt == c_CNT_MAX);
    w_half        = (r_cnt == c_CNT_HALF);
    w_bit_sample  = (r_state == c_DATA) && w_mid;
    w_stop_sample = (r_state == c_STOP) && w_mid;
`ifdef UART_RX_PARITY_EN
    w_par_bad     = (^r_shift) ^ r_par_bit;
`else
    w_par_bad     = 1'b0;
`endif
    w_byte_done   = w_stop_sample && r_rxs && !w_par_bad;
    w_frame_bad   = w_stop_sample && !r_rxs;
  end

  // Bit-period counter: half period in START, full periods thereafter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        c_START:        r_cnt <= w_half ? '0 : r_cnt + 1'b1;
        c_DATA, c_STOP: r_cnt <= w_mid  ? '0 : r_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        c_PARITY:       r_cnt <= w_mid  ? '0 : r_cnt + 1'b1;
`endif
        default:        r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
    end else if (r_state == c_IDLE) begin
      r_bit_cnt <= 3'd0;
    end else if (w_bit_sample) begin
      r_shift   <= {r_rxs, r_shift[7:1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == c_PARITY && w_mid) r_par_bit <= r_rxs;
      r_parity_err <= w_stop_sample && w_par_bad;
    end
  end
  assign rx_if.rx_parity_err = r_parity_err;
`endif

  // Simultaneous accept and new byte refills the register without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= 1'b0;
      if (w_byte_done && (!r_valid || rx_if.rx_ready)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else begin
        if (w_byte_done) r_overrun <= 1'b1;
        if (r_valid && rx_if.rx_ready) r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data_out  = r_data;
  assign rx_if.rx_valid     = r_valid;
  assign rx_if.rx_frame_err = r_frame_err;
  assign rx_if.rx_overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_byte_rx
// Purpose  : Directed self-checking bench for uart_byte_rx at 8 clocks/bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_byte_rx;
  localparam int P = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_serial;
  logic rx_enable;

  always #5 clk = ~clk;

  uart_byte_rx_if rx_if ();

  uart_byte_rx #(.CLKS_PER_BIT(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .rx_enable (rx_enable),
    .rx_if     (rx_if)
  );

  int errors = 0;
  int checks = 0;

  // Monitor: outputs seen at negedge are post-edge; an acceptance happened at
  // the edge just past when valid was high at the previous negedge.
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vcyc   = 0;
  logic [7:0] rxq[$];
  logic       m_pv   = 1'b0;
  logic [7:0] m_pd   = 8'h00;

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_pv && rx_if.rx_ready) rxq.push_back(m_pd);
      if (rx_if.rx_frame_err) fe_cnt++;
      if (rx_if.rx_overrun)   ov_cnt++;
      if (rx_if.rx_valid)     vcyc++;
      m_pv = rx_if.rx_valid;
      m_pd = rx_if.rx_data_out;
    end else begin
      m_pv = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic en_rest);
    rx_serial = 1'b0;
    cyc(P);
    rx_enable = en_rest;
    for (int b = 0; b < 8; b++) begin
      rx_serial = d[b];
      cyc(P);
    end
    rx_serial = stop;
    cyc(P);
    rx_serial = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       en;
    int         exp_n;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  int q0, fe0, ov0, v0;

  task automatic snap();
    q0  = rxq.size();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    v0  = vcyc;
  endtask

  function automatic logic [31:0] rx_at(input int idx);
    if (rxq.size() > idx) return 32'(rxq[idx]);
    return 32'hDEAD;
  endfunction

  initial begin
    vecs[0] = '{data: 8'hA5, stop: 1'b1, en: 1'b1, exp_n: 1, exp_fe: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, en: 1'b1, exp_n: 1, exp_fe: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, en: 1'b1, exp_n: 1, exp_fe: 0};
    vecs[3] = '{data: 8'h55, stop: 1'b1, en: 1'b0, exp_n: 0, exp_fe: 0};
    vecs[4] = '{data: 8'h3C, stop: 1'b0, en: 1'b1, exp_n: 0, exp_fe: 1};

    rst_n          = 1'b0;
    rx_serial      = 1'b1;
    rx_enable      = 1'b1;
    rx_if.rx_ready = 1'b1;
    cyc(3);
    check("reset_data",  32'(rx_if.rx_data_out),  32'h00);
    check("reset_valid", 32'(rx_if.rx_valid),     32'h0);
    check("reset_ferr",  32'(rx_if.rx_frame_err), 32'h0);
    check("reset_ovr",   32'(rx_if.rx_overrun),   32'h0);
    rst_n = 1'b1;
    cyc(2 * P);

    for (int i = 0; i < 5; i++) begin
      snap();
      rx_enable = vecs[i].en;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].en);
      cyc(3 * P);
      check($sformatf("vec%0d_nbytes", i), 32'(rxq.size() - q0), 32'(vecs[i].exp_n));
      if (vecs[i].exp_n > 0)
        check($sformatf("vec%0d_byte", i), rx_at(q0), 32'(vecs[i].data));
      check($sformatf("vec%0d_ferr", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_vcyc", i), 32'(vcyc - v0), 32'(vecs[i].exp_n));
      check($sformatf("vec%0d_ovr", i), 32'(ov_cnt - ov0), 32'h0);
    end
    rx_enable = 1'b1;

    // Short low glitch: rejected at the mid-start sample.
    snap();
    rx_serial = 1'b0;
    cyc(2);
    rx_serial = 1'b1;
    cyc(3 * P);
    check("glitch_nbytes", 32'(rxq.size() - q0), 32'h0);
    check("glitch_vcyc",   32'(vcyc - v0),       32'h0);
    check("glitch_ferr",   32'(fe_cnt - fe0),    32'h0);

    // Bad stop bit followed by a held-low line, then a good byte.
    snap();
    send_frame(8'h3C, 1'b0, 1'b1);
    rx_serial = 1'b0;
    cyc(30);
    rx_serial = 1'b1;
    cyc(2 * P);
    send_frame(8'h81, 1'b1, 1'b1);
    cyc(3 * P);
    check("break_ferr",   32'(fe_cnt - fe0),    32'h1);
    check("break_nbytes", 32'(rxq.size() - q0), 32'h1);
    check("break_byte",   rx_at(q0),            32'h81);

    // Overrun: consumer stalled across two bytes.
    snap();
    rx_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    cyc(3 * P);
    check("ovr_pulses", 32'(ov_cnt - ov0),        32'h1);
    check("ovr_data",   32'(rx_if.rx_data_out),   32'h11);
    check("ovr_valid",  32'(rx_if.rx_valid),      32'h1);
    rx_if.rx_ready = 1'b1;
    cyc(1);
    check("ovr_valid_clr", 32'(rx_if.rx_valid),    32'h0);
    check("ovr_accepted",  32'(rxq.size() - q0),   32'h1);
    check("ovr_acc_byte",  rx_at(q0),              32'h11);

    // Enable dropped after the start bit: frame still completes.
    snap();
    rx_enable = 1'b1;
    send_frame(8'h66, 1'b1, 1'b0);
    cyc(3 * P);
    rx_enable = 1'b1;
    check("en_drop_nbytes", 32'(rxq.size() - q0), 32'h1);
    check("en_drop_byte",   rx_at(q0),            32'h66);

    // Reset during data bit 4 while a byte is held.
    rx_if.rx_ready = 1'b0;
    send_frame(8'h77, 1'b1, 1'b1);
    cyc(3 * P);
    check("hold_data", 32'(rx_if.rx_data_out), 32'h77);
    rx_serial = 1'b0;
    cyc(P);
    for (int b = 0; b < 4; b++) begin
      rx_serial = (8'h99 >> b) & 8'h01;
      cyc(P);
    end
    rx_serial = 1'b1;
    cyc(P / 2);
    rst_n = 1'b0;
    #1;
    check("midrst_data",  32'(rx_if.rx_data_out),  32'h00);
    check("midrst_valid", 32'(rx_if.rx_valid),     32'h0);
    check("midrst_ferr",  32'(rx_if.rx_frame_err), 32'h0);
    check("midrst_ovr",   32'(rx_if.rx_overrun),   32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2 * P);
    snap();
    rx_if.rx_ready = 1'b1;
    send_frame(8'h42, 1'b1, 1'b1);
    cyc(3 * P);
    check("postrst_nbytes", 32'(rxq.size() - q0), 32'h1);
    check("postrst_byte",   rx_at(q0),            32'h42);
    check("postrst_ferr",   32'(fe_cnt - fe0),    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
- UART receiver that deserializes the rx pin into bytes.
- Presents each byte to the downstream SRAM command controller through a one-entry holding register with a valid/ready handshake (rx_data_out / rx_valid / rx_ready).
- Sits between the chip's serial input pin and the controller; the controller drives rx_enable and rx_ready.
- Frame format: 8N1, LSB first.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit; legal range is 4 or more. Sim uses 8.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter. Derived; not overridden.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_serial  input  1  asynchronous serial line; idles high
- rx_enable  input  1  permits detection of new start bits
- rx_ready  input  1  consumer accepts the held byte
- rx_data_out  output  8  held byte
- rx_valid  output  1  held byte is valid
- rx_frame_err  output  1  one-cycle pulse on a bad stop bit
- rx_overrun  output  1  one-cycle pulse when a completed byte is dropped

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n = 0: FSM goes to IDLE; rx_data_out = 0x00; rx_valid = 0; rx_frame_err = 0; rx_overrun = 0; counters = 0; synchronizer flops = 1.
  - Reset asserted mid-frame aborts the frame with no error flag.
- Synchronizer: rx_serial passes through a 2-flop synchronizer; all logic uses the synchronized value rxs.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rxs = 0 and rx_enable = 1 -> START, bit counter cleared.
  - rx_enable = 0 -> stay in IDLE; a low line is ignored.
- START:
  - At count CLKS_PER_BIT/2 - 1 (mid start bit), sample rxs.
  - rxs = 1 -> false start, back to IDLE, no flags.
  - rxs = 0 -> DATA, counter cleared.
- DATA:
  - Every CLKS_PER_BIT cycles (mid-bit), shift rxs into the shift register, LSB first.
  - After the 8th sample -> STOP.
- STOP (sample mid stop bit):
  - rxs = 1 -> byte is complete; return to IDLE.
  - rxs = 0 -> rx_frame_err pulses for one cycle; byte discarded; go to BREAK.
- BREAK: wait until rxs = 1, then IDLE. Prevents a held-low line from re-triggering.
- rx_enable deasserted mid-frame: the current frame completes normally; only new start detection is gated.
- Holding register and handshake:
  - Byte complete with rx_valid = 0: load rx_data_out; rx_valid = 1 on the next cycle.
  - rx_valid stays high and rx_data_out stays stable until a clock edge where rx_valid & rx_ready; then rx_valid clears on that edge.
  - Byte complete in the same cycle as rx_valid & rx_ready: load the new byte; rx_valid stays 1.
  - Byte complete with rx_valid = 1 and rx_ready = 0: new byte dropped, old byte kept, rx_overrun pulses for one cycle.
- Latency: from the rxs edge at the start of the stop bit to rx_valid = 1 is CLKS_PER_BIT/2 + 1 cycles.
- Counter: CNT_W bits; wraps to 0 at CLKS_PER_BIT - 1; never exceeds it.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a PARITY state is inserted between DATA and STOP.
  - Parity bit sampled mid-bit; an extra output rx_parity_err (1 bit, reset 0) pulses for one cycle at the stop-bit sample if the even parity mismatched.
  - Mismatched byte is discarded; holding register unchanged.
  - If the stop bit is also bad, both error pulses fire.
- Undefined: no PARITY state and no rx_parity_err port; frame is 8N1.

Test Plan (CLKS_PER_BIT = 8):
- Send 0xA5 (valid stop) with rx_ready = 1 -> rx_valid high exactly 1 cycle, rx_data_out = 0xA5, no flags.
- Low glitch on rx_serial for 2 cycles, then high -> no state beyond START, rx_valid stays 0, no flags.
- Send 0x3C with stop bit = 0, line held low 30 cycles, then send 0x81 -> rx_frame_err one pulse, no rx_valid for 0x3C, then 0x81 delivered.
- rx_ready = 0; send 0x11 then 0x22 -> rx_data_out stays 0x11, rx_overrun pulses once after 0x22's stop sample; raise rx_ready -> rx_valid clears next edge.
- rx_enable = 0, send 0x55 -> nothing received. Then rx_enable = 1, send 0x66, drop rx_enable after the start bit -> 0x66 still delivered.
- Assert rst_n = 0 during data bit 4 of 0x99 -> all outputs 0 immediately; after release, 0x42 received correctly.
